// File: rtl/multiword_adder_ctrl.sv
// multiword_adder_ctrl
//   Sequential multi-precision add/subtract. A single 8-bit ripple-carry
//   adder is reused once per byte, least-significant byte first, with the
//   inter-byte carry held in a register. Subtraction is A + ~B + 1.
//
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     start           request, sampled only while idle
//     op_sub          0 = a+b, 1 = a-b (latched with operands)
//     a, b            operands, 8*NBYTES bits, latched on accepted start
//     busy            high while bytes are being processed
//     done            one-cycle pulse, result valid
//     sum             result, updated only at completion
//     cout            carry out of the MSB (subtract: 1 = no borrow)
//     ovf             two's-complement signed overflow

module RippleCarryAdder8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);
    logic [8:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[8];
endmodule

module multiword_adder_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  op_sub,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout,
    output logic                  ovf
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic          carry;
    logic [W-1:0]  opa;
    logic [W-1:0]  opb;     // already conditioned: b ^ {W{op_sub}}
    logic [W-1:0]  res;

    logic [7:0]    add_s;
    logic          add_co;
    logic [W-1:0]  res_next;
    logic          last;
    logic          ovf_next;

    RippleCarryAdder8 u_add (
        .a    (opa[8*idx +: 8]),
        .b    (opb[8*idx +: 8]),
        .cin  (carry),
        .s    (add_s),
        .cout (add_co)
    );

    assign last = (idx == IW'(NBYTES - 1));

    // Overflow from sign bits: operands agree in sign, result disagrees.
    // Only meaningful while the top byte is on the adder.
    assign ovf_next = (opa[W-1] == opb[W-1]) && (add_s[7] != opa[W-1]);

    always_comb begin
        res_next              = res;
        res_next[8*idx +: 8]  = add_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
            carry <= 1'b0;
            opa   <= '0;
            opb   <= '0;
            res   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        opa   <= a;
                        opb   <= b ^ {W{op_sub}};
                        carry <= op_sub;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    res   <= res_next;
                    carry <= add_co;
                    if (last) begin
                        sum   <= res_next;
                        cout  <= add_co;
                        ovf   <= ovf_next;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        idx   <= '0;
                        state <= S_DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multiword_adder_ctrl.sv
module tb_multiword_adder_ctrl;
    logic        clk = 1'b0;
    logic        rst;

    // 4-byte instance
    logic        start, op_sub;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] sum;
    logic        cout, ovf;

    // 2-byte instance
    logic        start2, op_sub2;
    logic [15:0] a2, b2;
    logic        busy2, done2;
    logic [15:0] sum2;
    logic        cout2, ovf2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multiword_adder_ctrl #(.NBYTES(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .op_sub(op_sub),
        .a(a), .b(b), .busy(busy), .done(done),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    multiword_adder_ctrl #(.NBYTES(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .op_sub(op_sub2),
        .a(a2), .b(b2), .busy(busy2), .done(done2),
        .sum(sum2), .cout(cout2), .ovf(ovf2)
    );

    typedef struct {
        logic        op;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] es;
        logic        ec;
        logic        eo;
    } vec_t;

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endfunction

    // Reference: whole-word arithmetic on nb bytes. Returns {ovf, cout, sum}.
    function automatic logic [65:0] model(input int nb, input logic op,
                                          input logic [63:0] x, input logic [63:0] y);
        int          w;
        logic [64:0] mask, xx, yy, full;
        logic        c, o;
        w    = 8 * nb;
        mask = (65'd1 << w) - 65'd1;
        xx   = {1'b0, x} & mask;
        yy   = (op ? ~{1'b0, y} : {1'b0, y}) & mask;
        full = xx + yy + {64'd0, op};
        c    = full[w];
        o    = (xx[w-1] == yy[w-1]) && (full[w-1] != xx[w-1]);
        return {o, c, full[63:0] & mask[63:0]};
    endfunction

    task automatic run4(input logic op, input logic [31:0] ta, input logic [31:0] tb_,
                        input logic [31:0] es, input logic ec, input logic eo, input string tag);
        int lat, bcnt;
        bit seen;
        @(negedge clk);
        start = 1'b1; op_sub = op; a = ta; b = tb_;
        @(posedge clk); #1;
        // scramble inputs after accept; the latched operands must win
        start = 1'b0; op_sub = 1'($urandom); a = $urandom; b = $urandom;
        lat = 0; bcnt = 0; seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin seen = 1; break; end
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        chk({tag, "_sum"}, 64'(sum), 64'(es));
        chk({tag, "_cout"}, 64'(cout), 64'(ec));
        chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
        chk({tag, "_latency"}, 64'(lat), 64'd4);
        chk({tag, "_busy_cycles"}, 64'(bcnt), 64'd4);
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_sum_hold"}, 64'(sum), 64'(es));
    endtask

    task automatic run2(input logic op, input logic [15:0] ta, input logic [15:0] tb_,
                        input logic [15:0] es, input logic ec, input logic eo, input string tag);
        int lat;
        bit seen;
        @(negedge clk);
        start2 = 1'b1; op_sub2 = op; a2 = ta; b2 = tb_;
        @(posedge clk); #1;
        start2 = 1'b0; a2 = 16'($urandom); b2 = 16'($urandom);
        lat = 0; seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (done2) begin seen = 1; break; end
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        chk({tag, "_sum"}, 64'(sum2), 64'(es));
        chk({tag, "_cout"}, 64'(cout2), 64'(ec));
        chk({tag, "_ovf"}, 64'(ovf2), 64'(eo));
        chk({tag, "_latency"}, 64'(lat), 64'd2);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 64'(done2), 64'd0);
    endtask

    vec_t vecs[8];

    initial begin
        int dcnt, bseen;
        logic [65:0] m;
        logic        rop;
        logic [31:0] ra, rb;

        vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 32'h00FF_00FF, 32'h0001_0001, 32'h0100_0100, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 32'h0000_0007, 32'h0000_0005, 32'h0000_0002, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1};

        rst = 1'b1; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
        start2 = 1'b0; op_sub2 = 1'b0; a2 = '0; b2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_sum", 64'(sum), 64'd0);
        chk("reset_cout", 64'(cout), 64'd0);
        chk("reset_ovf", 64'(ovf), 64'd0);
        // rst overrides start on the same edge
        start = 1'b1; a = 32'h1; b = 32'h1;
        @(posedge clk); #1;
        chk("rst_over_start_busy", 64'(busy), 64'd0);
        start = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            run4(vecs[i].op, vecs[i].va, vecs[i].vb, vecs[i].es, vecs[i].ec, vecs[i].eo,
                 $sformatf("vec%0d", i));

        // start during RUN and DONE must be ignored
        @(negedge clk);
        start = 1'b1; op_sub = 1'b0; a = 32'h0000_1234; b = 32'h0000_0001;
        @(posedge clk); #1;
        a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; op_sub = 1'b1;   // start stays high
        bseen = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin bseen = 1; break; end
            @(posedge clk); #1;
        end
        chk("ign_first_done", 64'(bseen), 64'd1);
        chk("ign_first_sum", 64'(sum), 64'h1235);
        @(posedge clk); #1;          // start sampled during DONE
        start = 1'b0;
        dcnt = 0; bseen = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) dcnt++;
            if (busy) bseen++;
            @(posedge clk); #1;
        end
        chk("ign_no_second_done", 64'(dcnt), 64'd0);
        chk("ign_no_busy", 64'(bseen), 64'd0);
        chk("ign_sum_kept", 64'(sum), 64'h1235);
        run4(1'b0, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 1'b0, 1'b0, "after_ign");

        // reset mid-run: rst sampled at E2
        @(negedge clk);
        start = 1'b1; op_sub = 1'b0; a = 32'h1234_5678; b = 32'h1111_1111;
        @(posedge clk); #1;          // E0
        start = 1'b0;
        @(posedge clk); #1;          // E1
        rst = 1'b1;
        @(posedge clk); #1;          // E2
        rst = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_sum", 64'(sum), 64'd0);
        chk("midrst_cout", 64'(cout), 64'd0);
        chk("midrst_ovf", 64'(ovf), 64'd0);
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) dcnt++;
            @(posedge clk); #1;
        end
        chk("midrst_no_done", 64'(dcnt), 64'd0);
        run4(1'b0, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, "post_rst");

        // randomized against whole-word reference
        for (int i = 0; i < 40; i++) begin
            rop = 1'($urandom);
            ra  = $urandom;
            rb  = $urandom;
            if (i % 4 == 0) rb = ra;
            if (i % 5 == 1) rb = {ra[31], rb[30:0]};
            m = model(4, rop, 64'(ra), 64'(rb));
            run4(rop, ra, rb, m[31:0], m[64], m[65], $sformatf("rnd%0d", i));
        end

        // 2-byte instance
        run2(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, 1'b0, "nb2_ffff");
        for (int i = 0; i < 10; i++) begin
            logic [15:0] x, y;
            rop = 1'($urandom);
            x = 16'($urandom);
            y = 16'($urandom);
            m = model(2, rop, 64'(x), 64'(y));
            run2(rop, x, y, m[15:0], m[64], m[65], $sformatf("nb2_rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
